// File: rtl/crc_check.sv
// Per-frame CRC checker: payload words fold into the CRC, then the trailing word is compared. Optional length check via CRC_CHECK_LEN_EN.
// Latency: crc_done rises the cycle after the CRC-word handshake and is held until result_ack.
// Backpressure: data_ready drops while crc_rst is high and in DONE; it returns one cycle after result_ack.
module crc_check #(
   parameter logic [31:0] SEED  = 32'h52325032,
   parameter int          CNT_W = 16
) (
   input  logic             clk,
   input  logic             crc_rst,
   input  logic [31:0]      data_in,
   input  logic             data_valid,
   input  logic             data_last,
   output logic             data_ready,
   input  logic             result_ack,
`ifdef CRC_CHECK_LEN_EN
   input  logic [CNT_W-1:0] exp_len,
`endif
   output logic             crc_done,
   output logic             crc_ok,
   output logic [31:0]      crc_calc,
   output logic [CNT_W-1:0] word_cnt,
   output logic             len_err
);

   localparam logic [31:0] POLY = 32'h04C11DB7;

   typedef enum logic [1:0] {ST_RUN, ST_CHK, ST_DONE} state_t;

   state_t           r_st;
   logic [31:0]      r_crc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;
   logic             r_ok;
   logic             r_len_err;
   logic             r_ready;

   logic             w_hs;
   logic             w_match;
   logic             w_len_mis;
   logic [31:0]      w_next;

   // Shift 32 zero bits through the MSB-first LFSR: (data ^ crc) * x^32 mod P.
   function automatic logic [31:0] f_crc(input logic [31:0] v);
      logic [31:0] c;
      c = v;
      for (int i = 0; i < 32; i++) begin
         c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
      end
      return c;
   endfunction

   assign w_hs    = data_valid & data_ready;
   assign w_next  = f_crc(data_in ^ r_crc);
   assign w_match = (data_in == r_crc);

`ifdef CRC_CHECK_LEN_EN
   assign w_len_mis = (r_cnt != exp_len);
`else
   assign w_len_mis = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (crc_rst) begin
         r_st      <= ST_RUN;
         r_crc     <= SEED;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_ok      <= 1'b0;
         r_len_err <= 1'b0;
         r_ready   <= 1'b0;
      end else begin
         case (r_st)
            ST_RUN: begin
               r_ready <= 1'b1;
               if (w_hs) begin
                  r_crc <= w_next;
                  if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
                  if (data_last) r_st <= ST_CHK;
               end
            end
            ST_CHK: begin
               r_ready <= 1'b1;
               if (w_hs) begin
                  r_ok      <= w_match & ~w_len_mis;
                  r_len_err <= w_len_mis;
                  r_done    <= 1'b1;
                  r_ready   <= 1'b0;
                  r_st      <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_ready <= 1'b0;
               if (result_ack) begin
                  r_crc     <= SEED;
                  r_cnt     <= '0;
                  r_done    <= 1'b0;
                  r_ok      <= 1'b0;
                  r_len_err <= 1'b0;
                  r_ready   <= 1'b1;
                  r_st      <= ST_RUN;
               end
            end
            default: r_st <= ST_RUN;
         endcase
      end
   end

   // Gate with reset so the source sees not-ready for the whole reset window.
   assign data_ready = r_ready & ~crc_rst;
   assign crc_done   = r_done;
   assign crc_ok     = r_ok;
   assign crc_calc   = r_crc;
   assign word_cnt   = r_cnt;
   assign len_err    = r_len_err;

endmodule

// File: tb/tb_crc_check.sv
// Randomized bench for crc_check against a polynomial-division CRC model.
module tb_crc_check;

   localparam logic [31:0] SEED = 32'h52325032;

   logic        clk = 1'b0;
   logic        crc_rst = 1'b1;
   logic [31:0] data_in = '0;
   logic        data_valid = 1'b0;
   logic        data_last = 1'b0;
   logic        data_ready;
   logic        result_ack = 1'b0;
   logic [15:0] exp_len = '0;
   logic        crc_done;
   logic        crc_ok;
   logic [31:0] crc_calc;
   logic [15:0] word_cnt;
   logic        len_err;

   int total = 0;
   int bad = 0;
   logic [31:0] words [8];

   always #5 clk = ~clk;

   crc_check dut (
      .clk        (clk),
      .crc_rst    (crc_rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_last  (data_last),
      .data_ready (data_ready),
      .result_ack (result_ack),
`ifdef CRC_CHECK_LEN_EN
      .exp_len    (exp_len),
`endif
      .crc_done   (crc_done),
      .crc_ok     (crc_ok),
      .crc_calc   (crc_calc),
      .word_cnt   (word_cnt),
      .len_err    (len_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: remainder of ((crc ^ w) * x^32) by the 33-bit generator polynomial.
   function automatic logic [31:0] mdl_step(input logic [31:0] crc, input logic [31:0] w);
      logic [63:0] r;
      logic [63:0] p;
      r = {crc ^ w, 32'h0};
      p = 64'h1_04C1_1DB7;
      for (int i = 63; i >= 32; i--) begin
         if (r[i]) r = r ^ (p << (i - 32));
      end
      return r[31:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input bit last);
      int n;
      n = 0;
      data_in = d;
      data_valid = 1'b1;
      data_last = last;
      while (!data_ready && n < 50) begin
         step();
         n++;
      end
      if (!data_ready) chk("ready_timeout", {63'h0, data_ready}, 64'h1);
      step();
      data_valid = 1'b0;
      data_last = 1'b0;
   endtask

   task automatic run_frame(input int len, input bit bad_crc, input int hold, input int elen,
                            input bit gaps, input bit rst_exit);
      logic [31:0] c;
      logic [31:0] crcw;
      bit exp_ok;
      bit exp_le;
      c = SEED;
      for (int i = 0; i < len; i++) begin
         c = mdl_step(c, words[i]);
         if (gaps) repeat ($urandom_range(0, 2)) step();
         send(words[i], i == len - 1);
      end
      chk("calc_pre", crc_calc, c);
      chk("cnt_pre", word_cnt, len);
      chk("done_pre", crc_done, 0);
      crcw = bad_crc ? (c ^ 32'h1) : c;
`ifdef CRC_CHECK_LEN_EN
      exp_len = elen[15:0];
      exp_le = (elen != len);
`else
      exp_le = 1'b0;
      exp_len = elen[15:0];
`endif
      exp_ok = !bad_crc && !exp_le;
      send(crcw, $urandom_range(0, 1) == 1);
      chk("done", crc_done, 1);
      chk("ok", crc_ok, exp_ok);
      chk("len_err", len_err, exp_le);
      chk("calc_fin", crc_calc, c);
      chk("cnt_fin", word_cnt, len);
      data_valid = 1'b1;
      data_in = $urandom;
      for (int h = 0; h < hold; h++) begin
         step();
         chk("hold_rdy", data_ready, 0);
         chk("hold_done", crc_done, 1);
         chk("hold_calc", crc_calc, c);
         chk("hold_cnt", word_cnt, len);
      end
      data_valid = 1'b0;
      result_ack = 1'b1;
      if (rst_exit) crc_rst = 1'b1;
      step();
      result_ack = 1'b0;
      crc_rst = 1'b0;
      chk("ack_done", crc_done, 0);
      chk("ack_ok", crc_ok, 0);
      chk("ack_calc", crc_calc, SEED);
      chk("ack_cnt", word_cnt, 0);
      if (rst_exit) begin
         chk("rst_exit_rdy0", data_ready, 0);
         step();
      end
      chk("ack_rdy", data_ready, 1);
   endtask

   task automatic abort_frame(input int k);
      logic [31:0] c;
      c = SEED;
      for (int i = 0; i < k; i++) begin
         c = mdl_step(c, words[i]);
         send(words[i], 1'b0);
      end
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      chk("ack_ign_cnt", word_cnt, k);
      chk("ack_ign_calc", crc_calc, c);
      crc_rst = 1'b1;
      #1;
      chk("rdy_in_rst", data_ready, 0);
      step();
      crc_rst = 1'b0;
      chk("abort_calc", crc_calc, SEED);
      chk("abort_cnt", word_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("abort_nodone", crc_done, 0);
      end
   endtask

   initial begin
      int len;
      // T1: reset and seed
      repeat (3) step();
      chk("rst_rdy", data_ready, 0);
      chk("rst_done", crc_done, 0);
      crc_rst = 1'b0;
      step();
      chk("seed", crc_calc, SEED);
      chk("rst_cnt", word_cnt, 0);
      chk("rst_ok", crc_ok, 0);
      chk("rst_len_err", len_err, 0);
      chk("rdy_after_rst", data_ready, 1);

      // T2/T3: good and bad CRC on the fixed frame
      words[0] = 32'h00000001;
      words[1] = 32'h12345678;
      words[2] = 32'hDEADBEEF;
      run_frame(3, 1'b0, 0, 3, 1'b0, 1'b0);
      run_frame(3, 1'b1, 0, 3, 1'b0, 1'b0);

      // T4: hold in DONE, then back-to-back 1-word frame
      run_frame(3, 1'b0, 5, 3, 1'b0, 1'b0);
      words[0] = 32'hCAFEF00D;
      run_frame(1, 1'b0, 0, 1, 1'b0, 1'b0);

      // T5: mid-frame abort, then a clean frame; also reset with ack in DONE
      for (int i = 0; i < 4; i++) words[i] = $urandom;
      abort_frame(2);
      run_frame(4, 1'b0, 1, 4, 1'b0, 1'b1);
      run_frame(4, 1'b0, 0, 4, 1'b0, 1'b0);

`ifdef CRC_CHECK_LEN_EN
      // T6: length mismatch
      words[0] = 32'h00000001;
      words[1] = 32'h12345678;
      words[2] = 32'hDEADBEEF;
      run_frame(3, 1'b0, 0, 4, 1'b0, 1'b0);
      run_frame(3, 1'b0, 0, 3, 1'b0, 1'b0);
`endif

      for (int f = 0; f < 30; f++) begin
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) words[i] = $urandom;
         if (len > 1 && $urandom_range(0, 5) == 0)
            abort_frame($urandom_range(1, len - 1));
         else
            run_frame(len, $urandom_range(0, 2) == 0, $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0) ? len + 1 : len,
                      1'b1, $urandom_range(0, 7) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
